// File: rtl/iru_pkg.sv
// Shared types, constants and helpers for the image rotation unit.
package iru_pkg;

   localparam int IRU_WIN       = 20;
   localparam int IRU_CTR       = 10;
   localparam int IRU_ANG_STEPS = 36;
   localparam int IRU_SIN_OFS   = 27;
   localparam int IRU_FRAC_SH   = 7;

   typedef logic [4:0]        coord_t;
   typedef logic signed [9:0] trig_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } iru_state_t;

   // Last valid coordinate in either axis.
   localparam coord_t                IRU_LAST  = coord_t'(IRU_WIN - 1);
   // Centre at the widths used by the offset and source-coordinate math.
   localparam logic signed [5:0]     IRU_CTR_D = 6'(IRU_CTR);
   localparam logic signed [6:0]     IRU_CTR_S = 7'(IRU_CTR);
   localparam logic signed [6:0]     IRU_MAX_S = 7'(IRU_WIN - 1);
   // Half an integer step at the LUT scale, for round-half-up.
   localparam logic signed [12:0]    IRU_RND   = 13'(1 << (IRU_FRAC_SH - 1));

   // 9-bit sign-magnitude LUT word to two's complement; -0 becomes 0.
   function automatic trig_t sm_to_tc(input logic [8:0] sm);
      trig_t mag;
      mag = {2'b00, sm[7:0]};
      if (sm[8]) begin
         sm_to_tc = -mag;
      end else begin
         sm_to_tc = mag;
      end
   endfunction

endpackage

// File: rtl/iru_cos_lut.sv
// Cosine LUT addressed by a one-hot angle (bit 35-i = i*10 degrees).
// Output is 9-bit sign-magnitude scaled so 1.0 = 128.
module iru_cos_lut
   import iru_pkg::*;
(
   input  logic [IRU_ANG_STEPS-1:0] angle,
   output logic [8:0]               cos_sm
);

   function automatic logic [8:0] cos_tbl(input logic [5:0] i);
      case (i)
         6'd0:  cos_tbl = {1'b0, 8'd128};
         6'd1:  cos_tbl = {1'b0, 8'd126};
         6'd2:  cos_tbl = {1'b0, 8'd120};
         6'd3:  cos_tbl = {1'b0, 8'd111};
         6'd4:  cos_tbl = {1'b0, 8'd98};
         6'd5:  cos_tbl = {1'b0, 8'd82};
         6'd6:  cos_tbl = {1'b0, 8'd64};
         6'd7:  cos_tbl = {1'b0, 8'd44};
         6'd8:  cos_tbl = {1'b0, 8'd22};
         6'd9:  cos_tbl = {1'b0, 8'd0};
         6'd10: cos_tbl = {1'b1, 8'd22};
         6'd11: cos_tbl = {1'b1, 8'd44};
         6'd12: cos_tbl = {1'b1, 8'd64};
         6'd13: cos_tbl = {1'b1, 8'd82};
         6'd14: cos_tbl = {1'b1, 8'd98};
         6'd15: cos_tbl = {1'b1, 8'd111};
         6'd16: cos_tbl = {1'b1, 8'd120};
         6'd17: cos_tbl = {1'b1, 8'd126};
         6'd18: cos_tbl = {1'b1, 8'd128};
         6'd19: cos_tbl = {1'b1, 8'd126};
         6'd20: cos_tbl = {1'b1, 8'd120};
         6'd21: cos_tbl = {1'b1, 8'd111};
         6'd22: cos_tbl = {1'b1, 8'd98};
         6'd23: cos_tbl = {1'b1, 8'd82};
         6'd24: cos_tbl = {1'b1, 8'd64};
         6'd25: cos_tbl = {1'b1, 8'd44};
         6'd26: cos_tbl = {1'b1, 8'd22};
         6'd27: cos_tbl = {1'b0, 8'd0};
         6'd28: cos_tbl = {1'b0, 8'd22};
         6'd29: cos_tbl = {1'b0, 8'd44};
         6'd30: cos_tbl = {1'b0, 8'd64};
         6'd31: cos_tbl = {1'b0, 8'd82};
         6'd32: cos_tbl = {1'b0, 8'd98};
         6'd33: cos_tbl = {1'b0, 8'd111};
         6'd34: cos_tbl = {1'b0, 8'd120};
         6'd35: cos_tbl = {1'b0, 8'd126};
         default: cos_tbl = 9'd0;
      endcase
   endfunction

   // Select the table entry of the set angle bit.
   always_comb begin
      cos_sm = 9'd0;
      for (int p = 0; p < IRU_ANG_STEPS; p++) begin
         cos_sm = cos_sm | (angle[p] ? cos_tbl(6'(IRU_ANG_STEPS - 1 - p)) : 9'd0);
      end
   end

endmodule

// File: rtl/iru_onehot_idx.sv
// One-hot angle to index. Bit (35-i) set gives index i. valid is high only
// when exactly one bit is set; idx is meaningful only when valid.
module iru_onehot_idx
   import iru_pkg::*;
(
   input  logic [IRU_ANG_STEPS-1:0] onehot,
   output logic [5:0]               idx,
   output logic                     valid
);

   // OR together the index of every set bit, and test for exactly one set bit.
   always_comb begin
      idx = 6'd0;
      for (int p = 0; p < IRU_ANG_STEPS; p++) begin
         idx = idx | (onehot[p] ? 6'(IRU_ANG_STEPS - 1 - p) : 6'd0);
      end
      valid = (onehot != 36'd0) && ((onehot & (onehot - 36'd1)) == 36'd0);
   end

endmodule

// File: rtl/iru_rot_coord_gen.sv
// Rotation coordinate generator: walks a 20x20 destination window in raster
// order and emits the rotated source coordinate of every pixel through a
// 3-stage pipeline (counter, products, round/offset/range).
// Optional build macro IRU_COORD_FRAC_EN: truncating conversion plus
// 3-bit fractional source coordinate outputs.
module iru_rot_coord_gen
   import iru_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic [35:0] start_angle,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_row,
   output logic [4:0]  out_col,
   output logic [4:0]  src_row,
   output logic [4:0]  src_col,
   output logic        src_in_range,
   output logic        out_last,
   output logic        angle_err,
   output logic        busy
`ifdef IRU_COORD_FRAC_EN
  ,output logic [2:0]  src_row_frac,
   output logic [2:0]  src_col_frac
`endif
);

   iru_state_t state_r, state_s;
   coord_t     row_r, col_r;
   logic [5:0] ang_idx_r;

   logic [5:0]  dec_idx_s;
   logic        dec_valid_s;
   logic [35:0] cos_oh_s, sin_oh_s;
   logic [8:0]  cos_sm_s, sin_sm_s;
   trig_t       cos_s, sin_s;

   logic start_hs_s, advance_s, issue_s, last0_s;

   logic signed [5:0]  dx_s, dy_s;
   logic signed [12:0] cos_e_s, sin_e_s, dx_e_s, dy_e_s, ax_s, ay_s;

   logic               v1_r, last1_r;
   coord_t             row1_r, col1_r;
   logic signed [12:0] ax_r, ay_r;

   logic signed [6:0] shx_s, shy_s, sx_s, sy_s;
   logic              in_range_s;

   iru_onehot_idx u_dec (
      .onehot (start_angle),
      .idx    (dec_idx_s),
      .valid  (dec_valid_s)
   );

   // Latched angle back to one-hot; sin reads the LUT 27 steps further on.
   assign cos_oh_s = 36'h8_0000_0000 >> ang_idx_r;
   assign sin_oh_s = {cos_oh_s[IRU_SIN_OFS-1:0], cos_oh_s[IRU_ANG_STEPS-1:IRU_SIN_OFS]};

   iru_cos_lut u_cos (
      .angle  (cos_oh_s),
      .cos_sm (cos_sm_s)
   );

   iru_cos_lut u_sin (
      .angle  (sin_oh_s),
      .cos_sm (sin_sm_s)
   );

   assign cos_s = sm_to_tc(cos_sm_s);
   assign sin_s = sm_to_tc(sin_sm_s);

   assign start_ready = (state_r == ST_IDLE);
   assign busy        = (state_r != ST_IDLE);
   assign start_hs_s  = start_valid && start_ready;
   // A held output beat freezes every stage and the counter.
   assign advance_s   = !(out_valid && !out_ready);
   assign issue_s     = (state_r == ST_RUN) && advance_s;
   assign last0_s     = (row_r == IRU_LAST) && (col_r == IRU_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_hs_s) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (issue_s && last0_s) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (out_valid && out_ready && out_last) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Angle latch, error flag and the raster counter (stage 0).
   always_ff @(posedge clk) begin
      if (rst) begin
         row_r     <= 5'd0;
         col_r     <= 5'd0;
         ang_idx_r <= 6'd0;
         angle_err <= 1'b0;
      end else if (start_hs_s) begin
         row_r     <= 5'd0;
         col_r     <= 5'd0;
         ang_idx_r <= dec_valid_s ? dec_idx_s : 6'd0;
         angle_err <= !dec_valid_s;
      end else if (issue_s) begin
         if (col_r == IRU_LAST) begin
            col_r <= 5'd0;
            row_r <= (row_r == IRU_LAST) ? 5'd0 : row_r + 5'd1;
         end else begin
            col_r <= col_r + 5'd1;
         end
      end else begin
         row_r <= row_r;
         col_r <= col_r;
      end
   end

   // Stage 1 products: ax = cos*dx + sin*dy, ay = cos*dy - sin*dx.
   always_comb begin
      dx_s    = $signed({1'b0, col_r}) - IRU_CTR_D;
      dy_s    = $signed({1'b0, row_r}) - IRU_CTR_D;
      cos_e_s = {{3{cos_s[9]}}, cos_s};
      sin_e_s = {{3{sin_s[9]}}, sin_s};
      dx_e_s  = {{7{dx_s[5]}}, dx_s};
      dy_e_s  = {{7{dy_s[5]}}, dy_s};
      ax_s    = cos_e_s * dx_e_s + sin_e_s * dy_e_s;
      ay_s    = cos_e_s * dy_e_s - sin_e_s * dx_e_s;
   end

   // Stage 1 register.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r    <= 1'b0;
         last1_r <= 1'b0;
         row1_r  <= 5'd0;
         col1_r  <= 5'd0;
         ax_r    <= 13'sd0;
         ay_r    <= 13'sd0;
      end else if (advance_s) begin
         v1_r    <= issue_s;
         last1_r <= last0_s;
         row1_r  <= row_r;
         col1_r  <= col_r;
         ax_r    <= ax_s;
         ay_r    <= ay_s;
      end else begin
         v1_r    <= v1_r;
         last1_r <= last1_r;
      end
   end

   // Stage 2 scaling back to pixels, re-centring and range check.
   always_comb begin
`ifdef IRU_COORD_FRAC_EN
      shx_s = 7'(ax_r >>> IRU_FRAC_SH);
      shy_s = 7'(ay_r >>> IRU_FRAC_SH);
`else
      shx_s = 7'((ax_r + IRU_RND) >>> IRU_FRAC_SH);
      shy_s = 7'((ay_r + IRU_RND) >>> IRU_FRAC_SH);
`endif
      sx_s       = shx_s + IRU_CTR_S;
      sy_s       = shy_s + IRU_CTR_S;
      in_range_s = (sx_s >= 7'sd0) && (sx_s <= IRU_MAX_S) &&
                   (sy_s >= 7'sd0) && (sy_s <= IRU_MAX_S);
   end

   // Stage 2 output register; holds while the beat is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_row      <= 5'd0;
         out_col      <= 5'd0;
         src_row      <= 5'd0;
         src_col      <= 5'd0;
         src_in_range <= 1'b0;
`ifdef IRU_COORD_FRAC_EN
         src_row_frac <= 3'd0;
         src_col_frac <= 3'd0;
`endif
      end else if (advance_s) begin
         out_valid    <= v1_r;
         out_last     <= v1_r && last1_r;
         out_row      <= row1_r;
         out_col      <= col1_r;
         src_row      <= sy_s[4:0];
         src_col      <= sx_s[4:0];
         src_in_range <= in_range_s;
`ifdef IRU_COORD_FRAC_EN
         src_row_frac <= ay_r[6:4];
         src_col_frac <= ax_r[6:4];
`endif
      end else begin
         out_valid <= out_valid;
         out_last  <= out_last;
      end
   end

endmodule

// File: tb/tb_iru_rot_coord_gen.sv
// Directed bench for iru_rot_coord_gen: identity, 90 and 180 degree frames,
// stall, bad-angle and mid-frame reset scenarios.
module tb_iru_rot_coord_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic [35:0] start_angle;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_row, out_col, src_row, src_col;
   logic        src_in_range, out_last, angle_err, busy;

   int n_checks = 0;
   int n_fail   = 0;

   iru_rot_coord_gen dut (
      .clk          (clk),
      .rst          (rst),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .start_angle  (start_angle),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_row      (out_row),
      .out_col      (out_col),
      .src_row      (src_row),
      .src_col      (src_col),
      .src_in_range (src_in_range),
      .out_last     (out_last),
      .angle_err    (angle_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // kind: 0 identity, 1 rotate 90, 2 rotate 180.
   // stall_beat / abort_beat < 0 disables the stall / mid-frame reset.
   task automatic run_frame(input logic [35:0] ang, input int kind, input int stall_beat,
                            input int abort_beat, input logic exp_err);
      int          beats, cyc, first, stall_left, ready_bad;
      bit          done, stalled, aborted;
      logic [22:0] snap, cur;
      logic [4:0]  er, ec;
      beats = 0; cyc = 0; first = -1; stall_left = 0; ready_bad = 0;
      done = 1'b0; stalled = 1'b0; aborted = 1'b0; snap = 23'd0;

      @(negedge clk);
      chk("start_ready_idle", {31'd0, start_ready}, 32'd1);
      start_valid = 1'b1;
      start_angle = ang;
      out_ready   = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      start_angle = 36'h0_0000_0001;   // must be ignored while busy

      while (!done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         cur = {out_valid, out_last, src_in_range, out_row, out_col, src_row, src_col};
         if (cyc == 1) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("angle_err", {31'd0, angle_err}, {31'd0, exp_err});
         end
         if (abort_beat >= 0 && beats == abort_beat) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("rst_no_output", {31'd0, out_valid}, 32'd0);
            end
            aborted = 1'b1;
            done    = 1'b1;
         end else begin
            if (out_valid && first < 0) first = cyc;
            if (start_ready) ready_bad++;
            if (!stalled && stall_beat == beats && out_valid) begin
               stalled    = 1'b1;
               stall_left = 5;
               snap       = cur;
            end else if (stalled && beats == stall_beat) begin
               chk("stall_hold", {9'd0, cur}, {9'd0, snap});
            end
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
               er = 5'(beats / 20);
               ec = 5'(beats % 20);
               chk("dst", {22'd0, out_row, out_col}, {22'd0, er, ec});
               chk("last", {31'd0, out_last}, {31'd0, beats == 399});
               if (kind == 0)
                  chk("id_src", {21'd0, src_row, src_col, src_in_range}, {21'd0, er, ec, 1'b1});
               if (kind == 1 && beats == 0)
                  chk("r90_00_range", {31'd0, src_in_range}, 32'd0);
               if (kind == 1 && beats == 1)
                  chk("r90_01_src", {21'd0, src_row, src_col, src_in_range},
                      {21'd0, 5'd19, 5'd0, 1'b1});
               if (kind == 2 && beats == 0)
                  chk("r180_00_range", {31'd0, src_in_range}, 32'd0);
               if (kind == 2 && beats == 105)
                  chk("r180_55_src", {21'd0, src_row, src_col, src_in_range},
                      {21'd0, 5'd15, 5'd15, 1'b1});
               beats++;
               if (out_last) done = 1'b1;
            end
         end
      end

      chk("frame_done", {31'd0, done}, 32'd1);
      if (!aborted) begin
         chk("beat_count", beats, 32'd400);
         // Handshake edge, then two edges of latency: visible on the third negedge.
         chk("first_valid_lat", first, 32'd3);
         chk("ready_low_busy", ready_bad, 32'd0);
         @(negedge clk);
         chk("end_start_ready", {31'd0, start_ready}, 32'd1);
         chk("end_busy", {31'd0, busy}, 32'd0);
         chk("end_out_valid", {31'd0, out_valid}, 32'd0);
      end
      out_ready = 1'b1;
   endtask

   initial begin
      rst         = 1'b1;
      start_valid = 1'b0;
      start_angle = 36'd0;
      out_ready   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_err", {31'd0, angle_err}, 32'd0);
      chk("rst_busy0", {31'd0, busy}, 32'd0);
      chk("rst_ready1", {31'd0, start_ready}, 32'd1);
      chk("rst_coords", {11'd0, out_row, out_col, src_row, src_col, src_in_range}, 32'd0);
      rst = 1'b0;

      run_frame(36'h8_0000_0000, 0, -1, -1, 1'b0);   // 0 degrees
      run_frame(36'h0_0400_0000, 1, -1, -1, 1'b0);   // 90 degrees
      run_frame(36'h0_0002_0000, 2, -1, -1, 1'b0);   // 180 degrees
      run_frame(36'h0_0400_0000, 1, 100, -1, 1'b0);  // 90 degrees with stall
      run_frame(36'h0_0000_0000, 0, -1, -1, 1'b1);   // no bit set
      run_frame(36'h3_0000_0000, 0, -1, -1, 1'b1);   // two bits set
      run_frame(36'h8_0000_0000, 0, -1, -1, 1'b0);   // clears angle_err
      run_frame(36'h8_0000_0000, 0, -1, 50, 1'b0);   // reset at beat 50
      run_frame(36'h8_0000_0000, 0, -1, -1, 1'b0);   // full frame after reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iru_rot_coord_gen.md
Name: iru_rot_coord_gen

Overview:
Iterates a 20x20 destination window and, for each pixel, computes the source coordinate under rotation by a one-hot-encoded angle (36 steps of 10 degrees). Cos and sin come from the existing cos LUT, instanced twice. Downstream, the pixel-fetch stage reads the source buffer at (src_row, src_col) and zero-fills when the coordinate is out of range.

Parameters:
WIN, 20, window side in pixels; rows and columns are 0..WIN-1.
CTR, 10, rotation centre in both axes.
FRAC_SH, 7, LUT scale shift; 1.0 = 128.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_valid  in  1  request to rotate one window
start_ready  out  1  high only in IDLE
start_angle  in  36  one-hot angle; bit (35-i) = i*10 degrees
out_valid  out  1  output coordinate valid
out_ready  in  1  downstream accepts
out_row  out  5  destination row
out_col  out  5  destination column
src_row  out  5  source row; low 5 bits, valid only when src_in_range=1
src_col  out  5  source column; same rule as src_row
src_in_range  out  1  1 when both source coords lie in 0..WIN-1
out_last  out  1  high with destination pixel (19,19)
angle_err  out  1  sticky flag: last accepted angle was not exactly one-hot
busy  out  1  high when not IDLE

Behaviour:
- Reset values: out_valid=0, out_last=0, angle_err=0, busy=0, start_ready=1, all coordinate outputs 0. FSM goes to IDLE; counters and pipeline valids clear.
- Reset mid-frame aborts the frame immediately. No further outputs are produced. start_ready=1 on the cycle after reset deasserts.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start_valid && start_ready. The block latches angle index i and clears the (row, col) counter.
  - RUN issues one counter value per unstalled cycle, column-major-inner (col increments, wraps 19->0, row increments).
  - RUN -> DRAIN after issuing (19,19).
  - DRAIN -> IDLE when the output beat with out_last is accepted.
- Angle decode: if start_angle is not exactly one-hot (zero bits or more than one bit set), the block sets angle_err=1 and uses i=0 (identity). angle_err clears on the next accepted start that has a valid angle.
- cos = LUT(index i); sin = LUT(index (i+27) mod 36), since sin(t) = cos(t+270 degrees).
- LUT output is 9-bit sign-magnitude (bit8 = sign, bits7:0 = magnitude). Convert it to 10-bit two's complement; negative zero maps to 0.
- Pipeline, 3 stages. Stage 0 is the counter.
  - Stage 1: dx = col - CTR and dy = row - CTR (signed 6-bit). Compute 13-bit signed ax = cos*dx + sin*dy and ay = cos*dy - sin*dx.
  - Stage 2: sx = ((ax + 64) >>> 7) + CTR and sy = ((ay + 64) >>> 7) + CTR, using an arithmetic shift (round half up). Both are 7-bit signed. src_in_range = (0 <= sx,sy <= 19).
- Output register is stage 2. The first out_valid appears 2 cycles after the start handshake.
- Handshake and stall:
  - When out_valid && !out_ready, the whole pipeline and counter freeze and all outputs hold stable.
  - There are no bubbles when out_ready stays high: 400 consecutive beats.
- The start_angle value is ignored while busy.

Optional Feature:
IRU_COORD_FRAC_EN.
- Defined: adds ports src_row_frac and src_col_frac (out, 3 bits each). Stage 2 truncates instead of rounding: integer = (a >>> 7) + CTR, frac = a[6:4]. The range check uses the truncated integer.
- Undefined: no frac ports; rounding as specified in Behaviour.

Decomposition:
- Shared package iru_pkg holds:
  - IRU_WIN, IRU_CTR, IRU_ANG_STEPS=36, IRU_SIN_OFS=27
  - typedef coord_t (logic [4:0])
  - typedef trig_t (logic signed [9:0])
  - function sm_to_tc (9-bit sign-magnitude to trig_t)
- Sub-modules: instantiate iru_cos_lut twice, fed from a 36-bit angle rotated by the sin offset.
- One new sub-module, iru_onehot_idx: 36-bit one-hot to 6-bit index plus a valid flag.

Test Plan:
- 0 degrees (bit35 set), out_ready=1 -> 400 beats in raster order, src==dst and src_in_range=1 on every beat, out_last only on (19,19), first out_valid 2 cycles after the handshake.
- 90 degrees (bit26) -> dst(0,0) gives src_in_range=0 (sy=20); dst(0,1) gives src(row=19, col=0).
- 180 degrees (bit17) -> dst(5,5) gives src(15,15); dst(0,0) gives src_in_range=0.
- 90-degree frame with out_ready low for 5 cycles at beat 100 -> outputs hold stable throughout the stall, no drop or duplicate, 400 beats total, start_ready=0 until the final beat is accepted.
- start_angle=0, then a frame with 0x3_0000_0000 (two bits set) -> angle_err=1 and identity mapping for both frames. A following frame with bit35 set clears angle_err.
- rst asserted for 1 cycle at beat 50 -> out_valid=0 and busy=0 the next cycle, start_ready=1, and a new start runs a full 400-beat frame.
